regfile_sb: RTL and testbench

- Parametrised multi-port integer register file with a per-register pending-write scoreboard and write-to-read bypass.
- Next-generation replacement for the single-write, two-read core register file.
- Sits between decode (read addresses, issue of a destination register) and writeback (write port).
- Gives decode a one-signal hazard indication so the pipeline can stall on reads of registers with outstanding writes.

---
 rtl/regfile_sb_if.sv | 30 +++
 rtl/regfile_sb.sv | 83 ++++++++
 tb/tb_regfile_sb.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Register-file port bundle: decode read/issue side plus writeback side.
// The master drives addresses, writes and issue; the slave (regfile_sb) returns data and hazard state.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2
);
  localparam int NREG = 1 << AW;

  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_busy;
  logic                hazard;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic [NREG-1:0]     busy_vec;

  modport master (
    output rd_addr, we, wa, wd, iss_valid, iss_rd,
    input  rd_data, rd_busy, hazard, busy_vec
  );

  modport slave (
    input  rd_addr, we, wa, wd, iss_valid, iss_rd,
    output rd_data, rd_busy, hazard, busy_vec
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port integer register file with a pending-write scoreboard and
// same-cycle write-to-read forwarding for the decode/writeback boundary.
module regfile_sb #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int NRP     = 2,
  parameter bit ZERO_X0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int NREG = 1 << AW;

  logic [XLEN-1:0]     regs_r [NREG];
  logic [NREG-1:0]     busy_r;
  logic [NREG-1:0]     busy_nxt_s;
  logic                wr_en_s;
  logic [NRP*XLEN-1:0] rd_data_s;
  logic [NRP-1:0]      rd_busy_s;

  // A write to a hard-wired x0 is dropped and must never be forwarded.
  assign wr_en_s = bus.we && !(ZERO_X0 && (bus.wa == {AW{1'b0}}));

  // Register storage: cleared on reset, written by the writeback port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[bus.wa] <= bus.wd;
    end
  end

  // Scoreboard next state: issue sets, writeback clears, issue wins a tie.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < NREG; i++) begin
      if (bus.iss_valid && (bus.iss_rd == AW'(i))) begin
        busy_nxt_s[i] = 1'b1;
      end else if (bus.we && (bus.wa == AW'(i))) begin
        busy_nxt_s[i] = 1'b0;
      end else begin
        busy_nxt_s[i] = busy_r[i];
      end
    end
    busy_nxt_s[0] = ZERO_X0 ? 1'b0 : busy_nxt_s[0];
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Read ports: x0 first, then forwarding, then the array; busy is masked in reset.
  always_comb begin
    rd_data_s = {(NRP*XLEN){1'b0}};
    rd_busy_s = {NRP{1'b0}};
    for (int k = 0; k < NRP; k++) begin
      if (ZERO_X0 && (bus.rd_addr[k*AW +: AW] == {AW{1'b0}})) begin
        rd_data_s[k*XLEN +: XLEN] = {XLEN{1'b0}};
        rd_busy_s[k]              = 1'b0;
      end else if (BYPASS && !rst && wr_en_s && (bus.wa == bus.rd_addr[k*AW +: AW])) begin
        rd_data_s[k*XLEN +: XLEN] = bus.wd;
        rd_busy_s[k]              = 1'b0;
      end else begin
        rd_data_s[k*XLEN +: XLEN] = regs_r[bus.rd_addr[k*AW +: AW]];
        rd_busy_s[k]              = busy_r[bus.rd_addr[k*AW +: AW]] & ~rst;
      end
    end
  end

  assign bus.rd_data  = rd_data_s;
  assign bus.rd_busy  = rd_busy_s;
  assign bus.hazard   = |rd_busy_s;
  assign bus.busy_vec = busy_r;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a 4-port forwarding instance plus a
// 1-port non-forwarding instance sharing the same write/issue stimulus.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .AW(5), .NRP(4)) bus ();
  regfile_sb_if #(.XLEN(32), .AW(5), .NRP(1)) bus2 ();

  regfile_sb #(.XLEN(32), .AW(5), .NRP(4), .ZERO_X0(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  regfile_sb #(.XLEN(32), .AW(5), .NRP(1), .ZERO_X0(1'b1), .BYPASS(1'b0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  assign bus2.we        = bus.we;
  assign bus2.wa        = bus.wa;
  assign bus2.wd        = bus.wd;
  assign bus2.iss_valid = bus.iss_valid;
  assign bus2.iss_rd    = bus.iss_rd;

  typedef struct {
    string        nm;
    bit           cd;
    logic [127:0] d;
    bit           cb;
    logic [3:0]   b;
    logic         h;
    bit           cv;
    logic [31:0]  v;
    bit           c2;
    logic [31:0]  d2;
  } exp_t;

  exp_t q[$];
  exp_t e;
  exp_t x;
  int   tests = 0;
  int   fails = 0;

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      x = q.pop_front();
      if (x.cd) begin
        tests++;
        if (bus.rd_data !== x.d) begin
          fails++;
          $display("FAIL %s rd_data got %h exp %h", x.nm, bus.rd_data, x.d);
        end
      end
      if (x.cb) begin
        tests++;
        if ({bus.rd_busy, bus.hazard} !== {x.b, x.h}) begin
          fails++;
          $display("FAIL %s rd_busy/hazard got %b/%b exp %b/%b", x.nm, bus.rd_busy, bus.hazard, x.b, x.h);
        end
      end
      if (x.cv) begin
        tests++;
        if (bus.busy_vec !== x.v) begin
          fails++;
          $display("FAIL %s busy_vec got %h exp %h", x.nm, bus.busy_vec, x.v);
        end
      end
      if (x.c2) begin
        tests++;
        if (bus2.rd_data !== x.d2) begin
          fails++;
          $display("FAIL %s nobypass rd_data got %h exp %h", x.nm, bus2.rd_data, x.d2);
        end
      end
    end
  end

  task automatic clr_e();
    e.nm = ""; e.cd = 1'b0; e.d = 128'h0; e.cb = 1'b0; e.b = 4'h0; e.h = 1'b0;
    e.cv = 1'b0; e.v = 32'h0; e.c2 = 1'b0; e.d2 = 32'h0;
  endtask

  task automatic step();
    q.push_back(e);
    @(posedge clk);
    #1;
    clr_e();
  endtask

  task automatic addr4(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
    bus.rd_addr = {a3, a2, a1, a0};
  endtask

  function automatic logic [127:0] d4(input logic [31:0] p0, input logic [31:0] p1,
                                      input logic [31:0] p2, input logic [31:0] p3);
    return {p3, p2, p1, p0};
  endfunction

  task automatic exp_d(input string nm, input logic [127:0] d);
    e.nm = nm; e.cd = 1'b1; e.d = d;
  endtask

  task automatic exp_b(input logic [3:0] b, input logic h);
    e.cb = 1'b1; e.b = b; e.h = h;
  endtask

  task automatic exp_v(input logic [31:0] v);
    e.cv = 1'b1; e.v = v;
  endtask

  task automatic exp_2(input logic [31:0] d2);
    e.c2 = 1'b1; e.d2 = d2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_e();
    rst = 1'b1;
    bus.we = 1'b0; bus.wa = 5'd0; bus.wd = 32'h0;
    bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
    bus2.rd_addr = 5'd7;
    addr4(5'd5, 5'd5, 5'd5, 5'd5);
    @(posedge clk);
    #1;

    // reset held: issue ignored, busy masked
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    exp_d("rst_hold", 128'h0); exp_b(4'h0, 1'b0); exp_v(32'h0);
    step();
    rst = 1'b0; bus.iss_valid = 1'b0;
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h1234;
    exp_d("preload_fwd", {4{32'h1234}}); exp_v(32'h0);
    step();
    bus.we = 1'b0; bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    exp_d("preload", {4{32'h1234}}); exp_b(4'h0, 1'b0); exp_v(32'h0);
    step();
    // reset mid-operation: r5 busy, writeback in flight, no forwarding
    rst = 1'b1; bus.iss_valid = 1'b0;
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h9999;
    exp_d("rst_nofwd", {4{32'h1234}}); exp_b(4'h0, 1'b0); exp_v(32'h20);
    step();
    rst = 1'b0; bus.we = 1'b0;
    exp_d("post_rst", 128'h0); exp_b(4'h0, 1'b0); exp_v(32'h0);
    step();

    // x0 writes dropped, x0 never busy
    addr4(5'd0, 5'd0, 5'd0, 5'd0);
    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hDEADBEEF;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    exp_d("x0_same", 128'h0); exp_b(4'h0, 1'b0);
    step();
    bus.we = 1'b0; bus.iss_valid = 1'b0;
    exp_d("x0_after", 128'h0); exp_v(32'h0);
    step();

    // forwarding vs. non-forwarding instance
    bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h11;
    addr4(5'd0, 5'd0, 5'd0, 5'd0);
    e.nm = "r7_init"; exp_2(32'h0);
    step();
    bus.wd = 32'h22;
    addr4(5'd7, 5'd7, 5'd6, 5'd0);
    exp_d("bypass", d4(32'h22, 32'h22, 32'h0, 32'h0)); exp_2(32'h11);
    step();
    bus.we = 1'b0;
    exp_d("bypass_next", d4(32'h22, 32'h22, 32'h0, 32'h0)); exp_2(32'h22);
    step();

    // scoreboard set / hold / clear
    addr4(5'd3, 5'd0, 5'd0, 5'd0);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    e.nm = "sb_issue"; exp_b(4'h0, 1'b0); exp_v(32'h0);
    step();
    bus.iss_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e.nm = "sb_busy"; exp_b(4'h1, 1'b1); exp_v(32'h8);
      step();
    end
    bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h55;
    exp_d("sb_wb", d4(32'h55, 32'h0, 32'h0, 32'h0)); exp_b(4'h0, 1'b0); exp_v(32'h8);
    step();
    bus.we = 1'b0;
    exp_d("sb_clr", d4(32'h55, 32'h0, 32'h0, 32'h0)); exp_b(4'h0, 1'b0); exp_v(32'h0);
    step();

    // simultaneous set and clear on r9
    addr4(5'd9, 5'd0, 5'd0, 5'd0);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    e.nm = "r9_issue"; exp_v(32'h0);
    step();
    bus.iss_valid = 1'b0;
    e.nm = "r9_busy"; exp_b(4'h1, 1'b1); exp_v(32'h200);
    step();
    bus.iss_valid = 1'b1; bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h99;
    exp_d("setclr_same", d4(32'h99, 32'h0, 32'h0, 32'h0)); exp_b(4'h0, 1'b0); exp_v(32'h200);
    step();
    bus.iss_valid = 1'b0; bus.we = 1'b0;
    exp_d("setclr_after", d4(32'h99, 32'h0, 32'h0, 32'h0)); exp_b(4'h1, 1'b1); exp_v(32'h200);
    step();
    bus.we = 1'b1; bus.wd = 32'h77;
    exp_d("r9_wb", d4(32'h77, 32'h0, 32'h0, 32'h0)); exp_b(4'h0, 1'b0); exp_v(32'h200);
    step();
    bus.we = 1'b0;
    exp_d("r9_clr", d4(32'h77, 32'h0, 32'h0, 32'h0)); exp_b(4'h0, 1'b0); exp_v(32'h0);
    step();

    // multi-port on r12 with one port on r0
    addr4(5'd12, 5'd12, 5'd12, 5'd0);
    bus.we = 1'b1; bus.wa = 5'd12; bus.wd = 32'hA5A5;
    exp_d("mp_fwd", d4(32'hA5A5, 32'hA5A5, 32'hA5A5, 32'h0)); exp_b(4'h0, 1'b0);
    step();
    bus.we = 1'b0; bus.iss_valid = 1'b1; bus.iss_rd = 5'd12;
    exp_d("mp_read", d4(32'hA5A5, 32'hA5A5, 32'hA5A5, 32'h0)); exp_b(4'h0, 1'b0); exp_v(32'h0);
    step();
    bus.iss_valid = 1'b0;
    exp_d("mp_busy_d", d4(32'hA5A5, 32'hA5A5, 32'hA5A5, 32'h0)); exp_b(4'h7, 1'b1); exp_v(32'h1000);
    step();
    bus.we = 1'b1; bus.wd = 32'h5A;
    exp_d("mp_wb", d4(32'h5A, 32'h5A, 32'h5A, 32'h0)); exp_b(4'h0, 1'b0); exp_v(32'h1000);
    step();
    bus.we = 1'b0;
    exp_d("mp_clr", d4(32'h5A, 32'h5A, 32'h5A, 32'h0)); exp_b(4'h0, 1'b0); exp_v(32'h0);
    step();

    repeat (2) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain queue left %0d exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
